// File: rtl/window_generator_pkg.sv
// Shared window geometry helpers for the imaging library (window generator, mean filter).
package window_generator_pkg;

    function automatic int unsigned full_win_width(input int unsigned window_width);
        return window_width * window_width;
    endfunction

    // Accepted pixels needed before the oldest window row holds valid data.
    function automatic int unsigned fill_max(input int unsigned window_width,
                                             input int unsigned im_width);
        return (window_width - 1) * im_width + window_width;
    endfunction

endpackage

// File: rtl/window_generator_line_buffer.sv
// Single-port line RAM: asynchronous read returns the old word while the same address is written.
module line_buffer #(
    parameter int unsigned depth       = 320,
    parameter int unsigned color_width = 8,
    parameter int unsigned addr_bits   = 9
) (
    input  logic                   clk,
    input  logic                   we,
    input  logic [addr_bits-1:0]   addr,
    input  logic [color_width-1:0] wr_data,
    output logic [color_width-1:0] rd_data
);

    localparam int unsigned IDX_BITS = (depth > 1) ? $clog2(depth) : 1;

    logic [color_width-1:0] mem [depth];
    logic [IDX_BITS-1:0]    idx;

    assign idx     = IDX_BITS'(addr);
    assign rd_data = mem[idx];

    always_ff @(posedge clk) begin
        if (we) mem[idx] <= wr_data;
    end

endmodule

// File: rtl/window_generator.sv
// Sliding window_width x window_width window over a raster pixel stream using chained line buffers.
module window_generator
    import window_generator_pkg::*;
#(
    parameter int unsigned window_width  = 3,
    parameter int unsigned color_width   = 8,
    parameter int unsigned im_width      = 320,
    parameter int unsigned im_width_bits = 9
) (
    input  logic                                                     clk,
    input  logic                                                     rst,
    input  logic                                                     in_enable,
    input  logic [color_width-1:0]                                   in_data,
    output logic                                                     out_ready,
    output logic [color_width*full_win_width(window_width)-1:0]      out_data
);

    localparam int unsigned FILL_MAX  = fill_max(window_width, im_width);
    localparam int unsigned FILL_BITS = $clog2(FILL_MAX + 1);
    localparam logic [FILL_BITS-1:0]     FILL_LAST = FILL_BITS'(FILL_MAX);
    localparam logic [im_width_bits-1:0] COL_LAST  = im_width_bits'(im_width - 1);

    logic [im_width_bits-1:0] col;
    logic [FILL_BITS-1:0]     fill;
    logic [FILL_BITS-1:0]     fill_next;
    logic [color_width-1:0]   win     [window_width][window_width];
    logic [color_width-1:0]   lb_out  [window_width-1];
    logic [color_width-1:0]   new_col [window_width];

    // Buffer k delays by (k+1) rows and supplies window row window_width-2-k.
    assign new_col[window_width-1] = in_data;

    for (genvar k = 0; k < window_width - 1; k++) begin : g_lb
        logic [color_width-1:0] lb_in;
        if (k == 0) begin : g_head
            assign lb_in = in_data;
        end else begin : g_chain
            assign lb_in = lb_out[k-1];
        end

        line_buffer #(
            .depth      (im_width),
            .color_width(color_width),
            .addr_bits  (im_width_bits)
        ) u_line_buffer (
            .clk    (clk),
            .we     (in_enable),
            .addr   (col),
            .wr_data(lb_in),
            .rd_data(lb_out[k])
        );

        assign new_col[window_width-2-k] = lb_out[k];
    end

    assign fill_next = (fill == FILL_LAST) ? fill : fill + 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col       <= '0;
            fill      <= '0;
            out_ready <= 1'b0;
            for (int unsigned r = 0; r < window_width; r++)
                for (int unsigned c = 0; c < window_width; c++)
                    win[r][c] <= '0;
        end else if (!in_enable) begin
            col       <= '0;
            fill      <= '0;
            out_ready <= 1'b0;
        end else begin
            col       <= (col == COL_LAST) ? '0 : col + 1'b1;
            fill      <= fill_next;
            out_ready <= (fill_next == FILL_LAST);
            for (int unsigned r = 0; r < window_width; r++) begin
                for (int unsigned c = 0; c < window_width - 1; c++)
                    win[r][c] <= win[r][c+1];
                win[r][window_width-1] <= new_col[r];
            end
        end
    end

    always_comb begin
        out_data = '0;
        if (out_ready) begin
            for (int unsigned r = 0; r < window_width; r++)
                for (int unsigned c = 0; c < window_width; c++)
                    out_data[(r*window_width+c)*color_width +: color_width] = win[r][c];
        end
    end

endmodule

// File: tb/tb_window_generator.sv
// Directed bench: 3x3 and 2x2 windows over an 8-pixel-wide stream sharing one stimulus.
module tb_window_generator;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_enable;
    logic [7:0]  in_data;
    logic        ready3;
    logic [71:0] data3;
    logic        ready2;
    logic [31:0] data2;

    int n_checks = 0;
    int n_errors = 0;
    int acc      = 0;

    always #5 clk = ~clk;

    window_generator #(
        .window_width (3),
        .color_width  (8),
        .im_width     (8),
        .im_width_bits(3)
    ) u_dut3 (
        .clk      (clk),
        .rst      (rst),
        .in_enable(in_enable),
        .in_data  (in_data),
        .out_ready(ready3),
        .out_data (data3)
    );

    window_generator #(
        .window_width (2),
        .color_width  (8),
        .im_width     (8),
        .im_width_bits(3)
    ) u_dut2 (
        .clk      (clk),
        .rst      (rst),
        .in_enable(in_enable),
        .in_data  (in_data),
        .out_ready(ready2),
        .out_data (data2)
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One accepted pixel; readiness follows the bench's own accepted-pixel count.
    task automatic push(input logic [7:0] px);
        in_enable = 1'b1;
        in_data   = px;
        @(posedge clk);
        #1;
        acc++;
        check("ready3", {127'd0, ready3}, {127'd0, acc >= 19});
        check("ready2", {127'd0, ready2}, {127'd0, acc >= 10});
    endtask

    task automatic restart();
        in_enable = 1'b0;
        @(posedge clk);
        #1;
        acc = 0;
        check("restart_ready3", {127'd0, ready3}, 128'd0);
        check("restart_data3",  {56'd0, data3},   128'd0);
        check("restart_ready2", {127'd0, ready2}, 128'd0);
        check("restart_data2",  {96'd0, data2},   128'd0);
    endtask

    initial begin
        rst       = 1'b1;
        in_enable = 1'b0;
        in_data   = 8'd0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_ready3", {127'd0, ready3}, 128'd0);
        check("reset_data3",  {56'd0, data3},   128'd0);
        check("reset_ready2", {127'd0, ready2}, 128'd0);
        check("reset_data2",  {96'd0, data2},   128'd0);
        rst = 1'b0;

        // First fill: 2x2 ready after pixel 9, 3x3 after pixel 18.
        for (int n = 0; n <= 30; n++) begin
            push(8'(n));
            if (n == 9)
                check("first2", {96'd0, data2}, {96'd0, 8'd9, 8'd8, 8'd1, 8'd0});
            if (n == 17)
                check("almost3", {56'd0, data3}, 128'd0);
            if (n == 18)
                check("first3", {56'd0, data3},
                      {56'd0, 8'd18, 8'd17, 8'd16, 8'd10, 8'd9, 8'd8, 8'd2, 8'd1, 8'd0});
            if (n == 24) begin
                check("straddle3", {56'd0, data3},
                      {56'd0, 8'd24, 8'd23, 8'd22, 8'd16, 8'd15, 8'd14, 8'd8, 8'd7, 8'd6});
                check("straddle2", {96'd0, data2}, {96'd0, 8'd24, 8'd23, 8'd16, 8'd15});
            end
        end

        // Frame restart then 19 further pixels.
        restart();
        for (int n = 31; n <= 49; n++) begin
            push(8'(n));
            if (n == 40)
                check("refill2", {96'd0, data2}, {96'd0, 8'd40, 8'd39, 8'd32, 8'd31});
        end
        check("refill3", {56'd0, data3},
              {56'd0, 8'd49, 8'd48, 8'd47, 8'd41, 8'd40, 8'd39, 8'd33, 8'd32, 8'd31});

        // Asynchronous reset mid-frame clears outputs without a clock edge.
        #2;
        rst = 1'b1;
        #1;
        check("async_ready3", {127'd0, ready3}, 128'd0);
        check("async_data3",  {56'd0, data3},   128'd0);
        check("async_ready2", {127'd0, ready2}, 128'd0);
        check("async_data2",  {96'd0, data2},   128'd0);
        in_enable = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        acc = 0;
        for (int n = 0; n <= 18; n++) begin
            push(8'(n));
            if (n == 9)
                check("post_rst2", {96'd0, data2}, {96'd0, 8'd9, 8'd8, 8'd1, 8'd0});
        end
        check("post_rst3", {56'd0, data3},
              {56'd0, 8'd18, 8'd17, 8'd16, 8'd10, 8'd9, 8'd8, 8'd2, 8'd1, 8'd0});

        // Full-scale pixels.
        restart();
        for (int n = 0; n < 19; n++) push(8'd255);
        check("max3", {56'd0, data3}, {56'd0, {72{1'b1}}});
        check("max2", {96'd0, data2}, {96'd0, {32{1'b1}}});

        // Alternating enable: each low cycle clears the fill, so nothing becomes ready.
        for (int n = 0; n < 12; n++) begin
            restart();
            push(8'(n));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
